// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus between the FIFO writer and the write-pointer/full controller.
// The ovf_cnt signal exists only when WPTR_OVF_COUNT_EN is defined.
interface wptr_full_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic              w_en;
   logic [ADDR_W:0]   sync_rptr_gray;
   logic              w_ack;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wptr_bin;
   logic [ADDR_W:0]   wptr_gray;
   logic              full;
   logic              almost_full;
   logic [ADDR_W:0]   wlevel;
   logic              overflow;
`ifdef WPTR_OVF_COUNT_EN
   logic [7:0]        ovf_cnt;
`endif

   modport master (
      output w_en, sync_rptr_gray,
      input  w_ack, waddr, wptr_bin, wptr_gray, full, almost_full, wlevel, overflow
`ifdef WPTR_OVF_COUNT_EN
      , input ovf_cnt
`endif
   );

   modport slave (
      input  w_en, sync_rptr_gray,
      output w_ack, waddr, wptr_bin, wptr_gray, full, almost_full, wlevel, overflow
`ifdef WPTR_OVF_COUNT_EN
      , output ovf_cnt
`endif
   );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Async-FIFO write-domain pointer and full/level/overflow controller.
// Defining WPTR_OVF_COUNT_EN adds a saturating 8-bit overflow-attempt counter (ovf_cnt).
module wptr_full_ctrl #(
   parameter int ADDR_W       = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic              wclk,
   input  logic              wrst,
   wptr_full_ctrl_if.slave   bus
);
   localparam int            PW        = ADDR_W + 1;
   localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PW-1:0] wptr_bin_q,  wptr_bin_d;
   logic [PW-1:0] wptr_gray_q, wptr_gray_d;
   logic [PW-1:0] wlevel_q,    wlevel_d;
   logic          almost_full_q, almost_full_d;
   logic          overflow_q,  overflow_d;
   logic [PW-1:0] rbin_s;
   logic          full_s;
   logic          w_ack_s;
`ifdef WPTR_OVF_COUNT_EN
   logic [7:0]    ovf_cnt_q,   ovf_cnt_d;
`endif

   // Full detection, write acceptance and next-state computation.
   always_comb begin
      // Full when write pointer is one lap ahead: top two Gray bits inverted.
      full_s  = (wptr_gray_q == {~bus.sync_rptr_gray[ADDR_W:ADDR_W-1],
                                 bus.sync_rptr_gray[ADDR_W-2:0]});
      w_ack_s = bus.w_en & ~full_s & ~wrst;
      rbin_s  = gray2bin(bus.sync_rptr_gray);

      if (w_ack_s) begin
         wptr_bin_d  = wptr_bin_q + PW'(1);
         wptr_gray_d = bin2gray(wptr_bin_q + PW'(1));
      end else begin
         wptr_bin_d  = wptr_bin_q;
         wptr_gray_d = wptr_gray_q;
      end

      wlevel_d      = wptr_bin_d - rbin_s;
      almost_full_d = (wlevel_d >= AFULL_LVL);
      overflow_d    = overflow_q | (bus.w_en & full_s);

`ifdef WPTR_OVF_COUNT_EN
      if (bus.w_en && full_s && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end else begin
         ovf_cnt_d = ovf_cnt_q;
      end
`endif
   end

   // State registers; reset wins over any concurrent request.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         wptr_bin_q    <= {PW{1'b0}};
         wptr_gray_q   <= {PW{1'b0}};
         wlevel_q      <= {PW{1'b0}};
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
`ifdef WPTR_OVF_COUNT_EN
         ovf_cnt_q     <= 8'd0;
`endif
      end else begin
         wptr_bin_q    <= wptr_bin_d;
         wptr_gray_q   <= wptr_gray_d;
         wlevel_q      <= wlevel_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
`ifdef WPTR_OVF_COUNT_EN
         ovf_cnt_q     <= ovf_cnt_d;
`endif
      end
   end

   assign bus.w_ack       = w_ack_s;
   assign bus.full        = full_s;
   assign bus.waddr       = wptr_bin_q[ADDR_W-1:0];
   assign bus.wptr_bin    = wptr_bin_q;
   assign bus.wptr_gray   = wptr_gray_q;
   assign bus.wlevel      = wlevel_q;
   assign bus.almost_full = almost_full_q;
   assign bus.overflow    = overflow_q;
`ifdef WPTR_OVF_COUNT_EN
   assign bus.ovf_cnt     = ovf_cnt_q;
`endif

endmodule
